pwr_switch_ack_model: RTL



---
 rtl/pwr_switch_ack_model_if.sv | 34 +++
 rtl/pwr_switch_ack_model.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pwr_switch_ack_model_if.sv
// Request/acknowledge bundle between the harness and the power-switch model.
// The per-domain statistics counters exist only when PWR_SWITCH_ACK_STATS_EN is defined.
interface pwr_switch_ack_model_if #(
   parameter int NUM_DOMAINS = 4
);
   logic [NUM_DOMAINS-1:0]    switch_i;
   logic [NUM_DOMAINS-1:0]    iso_i;
   logic [NUM_DOMAINS-1:0]    ack_o;
   logic [NUM_DOMAINS-1:0]    busy_o;
   logic                      iso_err_o;
   logic [NUM_DOMAINS-1:0]    iso_err_dom_o;
`ifdef PWR_SWITCH_ACK_STATS_EN
   logic [NUM_DOMAINS*16-1:0] on_cnt_o;
   logic [NUM_DOMAINS*16-1:0] abort_cnt_o;

   modport master (
      output switch_i, iso_i,
      input  ack_o, busy_o, iso_err_o, iso_err_dom_o, on_cnt_o, abort_cnt_o
   );
   modport slave (
      input  switch_i, iso_i,
      output ack_o, busy_o, iso_err_o, iso_err_dom_o, on_cnt_o, abort_cnt_o
   );
`else
   modport master (
      output switch_i, iso_i,
      input  ack_o, busy_o, iso_err_o, iso_err_dom_o
   );
   modport slave (
      input  switch_i, iso_i,
      output ack_o, busy_o, iso_err_o, iso_err_dom_o
   );
`endif
endinterface

// File: rtl/pwr_switch_ack_model.sv
// Power-switch acknowledge model: one ramp FSM and 8-bit down-counter per domain plus an
// isolation-order checker. Define PWR_SWITCH_ACK_STATS_EN to add ramp statistics counters.
//
// state       | meaning
// ST_OFF      | domain unpowered, ack low
// ST_RAMP_ON  | powering up, ack low, counting ON_LATENCY
// ST_ON       | domain powered, ack high
// ST_RAMP_OFF | powering down, ack still high, counting OFF_LATENCY
module pwr_switch_ack_model #(
   parameter int NUM_DOMAINS = 4,
   parameter int ON_LATENCY  = 15,
   parameter int OFF_LATENCY = 15,
   parameter int RESET_ON    = 1
) (
   input logic                   clk_i,
   input logic                   rst_i,
   pwr_switch_ack_model_if.slave bus
);

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_RAMP_ON  = 2'd1,
      ST_ON       = 2'd2,
      ST_RAMP_OFF = 2'd3
   } state_t;

   localparam logic [7:0] ON_LOAD   = 8'(ON_LATENCY - 1);
   localparam logic [7:0] OFF_LOAD  = 8'(OFF_LATENCY - 1);
   localparam logic       ACK_RESET = (RESET_ON != 0);
   localparam state_t     ST_RESET  = (RESET_ON != 0) ? ST_ON : ST_OFF;

   if (ON_LATENCY < 1 || ON_LATENCY > 255) begin : g_bad_on_latency
      $error("pwr_switch_ack_model: ON_LATENCY %0d outside 1..255", ON_LATENCY);
   end
   if (OFF_LATENCY < 1 || OFF_LATENCY > 255) begin : g_bad_off_latency
      $error("pwr_switch_ack_model: OFF_LATENCY %0d outside 1..255", OFF_LATENCY);
   end

   logic [NUM_DOMAINS-1:0] ack_vec;
   logic [NUM_DOMAINS-1:0] busy_vec;
   logic [NUM_DOMAINS-1:0] err_vec;
`ifdef PWR_SWITCH_ACK_STATS_EN
   logic [NUM_DOMAINS*16-1:0] on_cnt_vec;
   logic [NUM_DOMAINS*16-1:0] abort_cnt_vec;
`endif

   for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
      state_t     state_q, state_d;
      logic [7:0] cnt_q, cnt_d;
      logic       ack_q, ack_d;
      logic       busy_q, busy_d;
      logic       err_q, err_d;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= ST_RESET;
            cnt_q   <= 8'd0;
            ack_q   <= ACK_RESET;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_OFF: begin
               if (bus.switch_i[d]) begin
                  state_d = ST_RAMP_ON;
                  cnt_d   = ON_LOAD;
               end
            end
            ST_RAMP_ON: begin
               if (!bus.switch_i[d]) begin
                  state_d = ST_OFF;
               end else if (cnt_q == 8'd0) begin
                  state_d = ST_ON;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_ON: begin
               if (!bus.switch_i[d]) begin
                  state_d = ST_RAMP_OFF;
                  cnt_d   = OFF_LOAD;
               end
            end
            ST_RAMP_OFF: begin
               if (bus.switch_i[d]) begin
                  state_d = ST_ON;
               end else if (cnt_q == 8'd0) begin
                  state_d = ST_OFF;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = ST_RESET;
         endcase
         // ack/busy are registered from the next state so they move on the same edge as the FSM
         ack_d  = (state_d == ST_ON) || (state_d == ST_RAMP_OFF);
         busy_d = (state_d == ST_RAMP_ON) || (state_d == ST_RAMP_OFF);
         err_d  = err_q | (~bus.iso_i[d] & ~ack_q);
      end

      assign ack_vec[d]  = ack_q;
      assign busy_vec[d] = busy_q;
      assign err_vec[d]  = err_q;

`ifdef PWR_SWITCH_ACK_STATS_EN
      logic [15:0] on_cnt_q;
      logic [15:0] abort_cnt_q;
      logic        done_on;
      logic        aborted;

      assign done_on = (state_q == ST_RAMP_ON) && (state_d == ST_ON);
      assign aborted = ((state_q == ST_RAMP_ON)  && (state_d == ST_OFF)) ||
                       ((state_q == ST_RAMP_OFF) && (state_d == ST_ON));

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            on_cnt_q    <= 16'd0;
            abort_cnt_q <= 16'd0;
         end else begin
            if (done_on && (on_cnt_q != 16'hFFFF)) begin
               on_cnt_q <= on_cnt_q + 16'd1;
            end
            if (aborted && (abort_cnt_q != 16'hFFFF)) begin
               abort_cnt_q <= abort_cnt_q + 16'd1;
            end
         end
      end

      assign on_cnt_vec[d*16 +: 16]    = on_cnt_q;
      assign abort_cnt_vec[d*16 +: 16] = abort_cnt_q;
`endif
   end

   assign bus.ack_o         = ack_vec;
   assign bus.busy_o        = busy_vec;
   assign bus.iso_err_dom_o = err_vec;
   assign bus.iso_err_o     = |err_vec;
`ifdef PWR_SWITCH_ACK_STATS_EN
   assign bus.on_cnt_o      = on_cnt_vec;
   assign bus.abort_cnt_o   = abort_cnt_vec;
`endif

endmodule
